fpu_i2f_operand_stage: RTL and testbench
========================================

Name: fpu_i2f_operand_stage

Overview:
- Registered operand-preparation stage sitting directly upstream of the integer-to-F32 converter in the FPU datapath.
- Accepts 32-bit integer operands (signed or unsigned) over a valid/ready handshake and buffers them in a 2-entry in-order skid buffer.
- Emits sign, absolute magnitude, leading-zero count and zero flag per operand. The converter only normalises, rounds and packs; it does no sign or LZC work.

Parameters:
- TAG_WIDTH, 4, width of the opaque tag carried alongside each operand, returned unmodified.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- FLUSH  input  1  synchronous discard of all buffered entries.
- IN_VALID  input  1  upstream operand valid.
- IN_READY  output  1  stage can accept an operand this cycle.
- IN_DATA  input  32  integer operand.
- IN_UNSIGNED  input  1  1 = treat IN_DATA as unsigned; 0 = two's complement.
- IN_TAG  input  TAG_WIDTH  sideband tag.
- OUT_VALID  output  1  head entry valid.
- OUT_READY  input  1  converter consumes head entry.
- OUT_SIGN  output  1  result sign (0 for unsigned or non-negative).
- OUT_MAG  output  32  absolute magnitude.
- OUT_LZC  output  6  leading zeros of OUT_MAG, 0..32.
- OUT_ZERO  output  1  OUT_MAG == 0.
- OUT_TAG  output  TAG_WIDTH  tag of head entry.
- OCCUPANCY  output  2  buffered entry count, 0..2.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- On RST: count = 0, OUT_VALID = 0, IN_READY = 1, OCCUPANCY = 0. All OUT_* data outputs = 0 (sign, magnitude, LZC, zero, tag).
- Handshakes:
  - Push = IN_VALID & IN_READY.
  - Pop = OUT_VALID & OUT_READY.
  - IN_READY = (count < 2). It is a function of registered count only, never of OUT_READY.
- Storage: 2-entry circular buffer with 1-bit write and read pointers that wrap 1→0.
  - Each entry holds {sign, mag, lzc, zero, tag}, computed combinationally from IN_* at push time and registered.
- Latency: an operand pushed in cycle N appears on OUT_* with OUT_VALID = 1 in cycle N+1 when the buffer was empty. There is no combinational in→out path.
- Throughput: 1 operand/cycle sustained while OUT_READY stays high.
- Arithmetic:
  - Signed (IN_UNSIGNED = 0): sign = IN_DATA[31]; mag = sign ? (~IN_DATA + 1) : IN_DATA.
  - 0x80000000 signed gives sign = 1, mag = 0x80000000. This is a legal 32-bit magnitude, not an overflow.
  - Unsigned: sign = 0; mag = IN_DATA.
  - lzc = count of leading zeros of mag. The value is 32 when mag = 0, and zero = 1 only in that case.
  - A signed or unsigned 0 always gives sign = 0.
- OUT_* present the head entry while OUT_VALID = 1. They hold stable until pop; upstream changes have no effect.
- Outputs while empty: OUT_VALID = 0, and OUT_* data hold the last popped entry's values (don't-care to the consumer).
- Simultaneous push and pop:
  - count 1: push and pop in the same cycle leaves count = 1; the new entry becomes the head next cycle.
  - count 2: push is impossible (IN_READY = 0). Pop makes count = 1, so IN_READY = 1 next cycle. One bubble is accepted by design.
  - count 0: pop is impossible.
- FLUSH:
  - Next cycle: count = 0, pointers = 0, OUT_VALID = 0, IN_READY = 1.
  - A push in the FLUSH cycle is discarded. A pop in the FLUSH cycle completes from the consumer's side.
  - FLUSH has no effect on OUT_* data values.
- RST has priority over FLUSH, push and pop. RST asserted mid-stream drops all entries with no partial output.
- OCCUPANCY = count, registered.
- Assertions:
  - Push never occurs when count = 2.
  - OUT_* are stable while OUT_VALID & ~OUT_READY.
  - OUT_LZC ≤ 32, and OUT_ZERO equals (OUT_LZC == 32).

Test Plan:
- Signed -1:
  - Stimulus: IN_DATA = 0xFFFFFFFF, IN_UNSIGNED = 0, tag 3, OUT_READY = 1.
  - Required next cycle: OUT_SIGN = 1, OUT_MAG = 0x00000001, OUT_LZC = 31, OUT_ZERO = 0, OUT_TAG = 3.
- Most-negative / unsigned max:
  - Stimulus: 0x80000000 signed, then 0xFFFFFFFF unsigned, back-to-back.
  - Required, in order: {1, 0x80000000, LZC 0}, then {0, 0xFFFFFFFF, LZC 0}, on consecutive cycles.
- Zero:
  - Stimulus: IN_DATA = 0 signed.
  - Required: OUT_SIGN = 0, OUT_MAG = 0, OUT_LZC = 32, OUT_ZERO = 1.
- Backpressure:
  - Stimulus: OUT_READY = 0, push 5, 6, 7 on consecutive cycles.
  - Required: 5 and 6 accepted, then IN_READY = 0 and OCCUPANCY = 2; 7 is held by upstream. Outputs stay on 5 while stalled.
  - Then release OUT_READY: order is 5, 6, 7 with 7 accepted one cycle after the first pop. LZC values: 29, 29, 29.
- Flush mid-stream:
  - Stimulus: two entries buffered, FLUSH pulsed with IN_VALID = 1 (operand 9).
  - Required next cycle: OUT_VALID = 0, OCCUPANCY = 0, IN_READY = 1; operand 9 never appears.
- Reset mid-stream:
  - Stimulus: RST with 1 entry buffered and simultaneous push/pop.
  - Required next cycle: all outputs at reset values, OCCUPANCY = 0.

Source files
------------

// File: rtl/fpu_i2f_operand_stage.sv
// ============================================================================
// Module      : fpu_i2f_operand_stage
// Description : Integer operand preparation for the I2F converter: sign,
//               magnitude, leading-zero count and zero flag, buffered in a
//               2-entry in-order skid buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fpu_i2f_operand_stage #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_unsigned,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [31:0]          out_mag,
    output logic [5:0]           out_lzc,
    output logic                 out_zero,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [1:0]           occupancy
);

    localparam logic [1:0] c_DEPTH = 2'd2;
    localparam logic [5:0] c_LZC_ZERO = 6'd32;

    // Buffer storage, indexed by 1-bit wrapping pointers
    logic                 r_sign [0:1];
    logic [31:0]          r_mag  [0:1];
    logic [5:0]           r_lzc  [0:1];
    logic                 r_zero [0:1];
    logic [TAG_WIDTH-1:0] r_tag  [0:1];

    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic                 r_out_sign;
    logic [31:0]          r_out_mag;
    logic [5:0]           r_out_lzc;
    logic                 r_out_zero;
    logic [TAG_WIDTH-1:0] r_out_tag;

    logic                 w_neg;
    logic                 w_sign;
    logic [31:0]          w_mag;
    logic [5:0]           w_lzc;
    logic                 w_zero;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_wr_en;
    logic                 w_wr_ptr_nxt;
    logic                 w_rd_ptr_nxt;
    logic [1:0]           w_count_nxt;
    logic                 w_out_upd;
    logic                 w_head_from_in;

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    // Negating 0x80000000 wraps back to 0x80000000, which is exactly the
    // required magnitude, so no special case is needed.
    assign w_neg  = ~in_unsigned & in_data[31];
    assign w_sign = w_neg;
    assign w_mag  = w_neg ? (~in_data + 32'd1) : in_data;
    assign w_zero = (w_mag == 32'd0);

    // Highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        w_lzc = c_LZC_ZERO;
        for (int i = 0; i < 32; i++) begin
            if (w_mag[i]) begin
                w_lzc = 6'(31 - i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake and pointer control
    // ------------------------------------------------------------------
    assign in_ready  = (r_count < c_DEPTH);
    assign out_valid = (r_count != 2'd0);
    assign occupancy = r_count;

    assign w_push  = in_valid & in_ready;
    assign w_pop   = out_valid & out_ready;
    assign w_wr_en = w_push & ~flush;

    assign w_wr_ptr_nxt = flush ? 1'b0 : (r_wr_ptr ^ w_push);
    assign w_rd_ptr_nxt = flush ? 1'b0 : (r_rd_ptr ^ w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = 2'(r_count + 2'd1);
                2'b01:   w_count_nxt = 2'(r_count - 2'd1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Output registers track the next head; when the buffer drains or is
    // flushed they keep the previous values so data never glitches.
    assign w_out_upd      = ~flush & (w_count_nxt != 2'd0);
    assign w_head_from_in = w_wr_en & (r_wr_ptr == w_rd_ptr_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_sign[i] <= 1'b0;
                r_mag[i]  <= 32'd0;
                r_lzc[i]  <= 6'd0;
                r_zero[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_out_sign <= 1'b0;
            r_out_mag  <= 32'd0;
            r_out_lzc  <= 6'd0;
            r_out_zero <= 1'b0;
            r_out_tag  <= '0;
        end else begin
            if (w_wr_en) begin
                r_sign[r_wr_ptr] <= w_sign;
                r_mag[r_wr_ptr]  <= w_mag;
                r_lzc[r_wr_ptr]  <= w_lzc;
                r_zero[r_wr_ptr] <= w_zero;
                r_tag[r_wr_ptr]  <= in_tag;
            end
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_out_upd) begin
                if (w_head_from_in) begin
                    r_out_sign <= w_sign;
                    r_out_mag  <= w_mag;
                    r_out_lzc  <= w_lzc;
                    r_out_zero <= w_zero;
                    r_out_tag  <= in_tag;
                end else begin
                    r_out_sign <= r_sign[w_rd_ptr_nxt];
                    r_out_mag  <= r_mag[w_rd_ptr_nxt];
                    r_out_lzc  <= r_lzc[w_rd_ptr_nxt];
                    r_out_zero <= r_zero[w_rd_ptr_nxt];
                    r_out_tag  <= r_tag[w_rd_ptr_nxt];
                end
            end
        end
    end

    assign out_sign = r_out_sign;
    assign out_mag  = r_out_mag;
    assign out_lzc  = r_out_lzc;
    assign out_zero = r_out_zero;
    assign out_tag  = r_out_tag;

    // ------------------------------------------------------------------
    // Protocol and datapath invariants
    // ------------------------------------------------------------------
    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        !(in_valid && in_ready && (r_count == c_DEPTH)));

    a_stable_on_stall : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            $stable({out_sign, out_mag, out_lzc, out_zero, out_tag}));

    a_lzc_range : assert property (@(posedge clk) disable iff (rst)
        (out_lzc <= c_LZC_ZERO) && (out_zero == (out_lzc == c_LZC_ZERO)));

endmodule

`default_nettype wire

// File: tb/tb_fpu_i2f_operand_stage.sv
// ============================================================================
// Module      : tb_fpu_i2f_operand_stage
// Description : Directed and randomised checks of the I2F operand stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_i2f_operand_stage;

    typedef struct packed {
        logic        sign;
        logic [31:0] mag;
        logic [5:0]  lzc;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_unsigned;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [31:0] out_mag;
    logic [5:0]  out_lzc;
    logic        out_zero;
    logic [3:0]  out_tag;
    logic [1:0]  occupancy;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t m_q[$];
    exp_t m_shown;

    fpu_i2f_operand_stage #(.TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_unsigned(in_unsigned), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_mag(out_mag), .out_lzc(out_lzc),
        .out_zero(out_zero), .out_tag(out_tag), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Reference: integer value -> sign/abs via plain arithmetic, LZC from bit length
    function automatic exp_t ref_model(input logic [31:0] d, input logic u, input logic [3:0] t);
        longint v;
        longint m;
        exp_t   e;
        if (u) v = longint'(d);
        else   v = longint'(int'(d));
        m      = (v < 0) ? -v : v;
        e.sign = (v < 0);
        e.mag  = m[31:0];
        e.lzc  = 6'(32 - $clog2(m + 1));
        e.zero = (m == 0);
        e.tag  = t;
        return e;
    endfunction

    function automatic exp_t obs();
        return {out_sign, out_mag, out_lzc, out_zero, out_tag};
    endfunction

    function automatic exp_t mk(input logic s, input logic [31:0] m, input logic [5:0] l,
                                input logic z, input logic [3:0] t);
        return {s, m, l, z, t};
    endfunction

    // Advance one clock and keep the queue model in step with the handshake
    task automatic cycle();
        bit   p;
        bit   q;
        exp_t e;
        p = in_valid && !rst && (m_q.size() < 2);
        q = out_ready && !rst && (m_q.size() > 0);
        e = ref_model(in_data, in_unsigned, in_tag);
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_shown = '0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            if (q) void'(m_q.pop_front());
            if (p) m_q.push_back(e);
        end
        if (m_q.size() > 0) m_shown = m_q[0];
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic u, input logic [3:0] t);
        in_valid    = 1'b1;
        in_data     = d;
        in_unsigned = u;
        in_tag      = t;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 32'd0; in_unsigned = 1'b0; in_tag = 4'd0;
        cycle(); cycle();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_ctrl: valid=%b ready=%b occ=%0d, want 0 1 0", out_valid, in_ready, occupancy);
        end
        n_checks++;
        if (obs() !== exp_t'(0)) begin
            n_errors++;
            $display("FAIL reset_data: got %h want 0", obs());
        end
    endtask

    task automatic test_signed_neg_one();
        out_ready = 1'b1;
        drive(32'hFFFF_FFFF, 1'b0, 4'd3);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || obs() !== mk(1'b1, 32'd1, 6'd31, 1'b0, 4'd3)) begin
            n_errors++;
            $display("FAIL neg_one: valid=%b data=%h want valid=1 data=%h", out_valid, obs(), mk(1'b1, 32'd1, 6'd31, 1'b0, 4'd3));
        end
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_errors++;
            $display("FAIL neg_one_drain: valid=%b occ=%0d want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_extremes();
        out_ready = 1'b1;
        drive(32'h8000_0000, 1'b0, 4'd1);
        cycle();
        drive(32'hFFFF_FFFF, 1'b1, 4'd2);
        n_checks++;
        if (out_valid !== 1'b1 || obs() !== mk(1'b1, 32'h8000_0000, 6'd0, 1'b0, 4'd1)) begin
            n_errors++;
            $display("FAIL most_neg: valid=%b data=%h want 1 %h", out_valid, obs(), mk(1'b1, 32'h8000_0000, 6'd0, 1'b0, 4'd1));
        end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || obs() !== mk(1'b0, 32'hFFFF_FFFF, 6'd0, 1'b0, 4'd2)) begin
            n_errors++;
            $display("FAIL umax: valid=%b data=%h want 1 %h", out_valid, obs(), mk(1'b0, 32'hFFFF_FFFF, 6'd0, 1'b0, 4'd2));
        end
        cycle();
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        drive(32'd0, 1'b0, 4'd4);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || obs() !== mk(1'b0, 32'd0, 6'd32, 1'b1, 4'd4)) begin
            n_errors++;
            $display("FAIL zero: valid=%b data=%h want 1 %h", out_valid, obs(), mk(1'b0, 32'd0, 6'd32, 1'b1, 4'd4));
        end
        cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(32'd5, 1'b0, 4'd5);
        cycle();
        n_checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_mag !== 32'd5 || out_lzc !== 6'd29) begin
            n_errors++;
            $display("FAIL bp_first: occ=%0d ready=%b mag=%0d lzc=%0d want 1 1 5 29", occupancy, in_ready, out_mag, out_lzc);
        end
        drive(32'd6, 1'b0, 4'd6);
        cycle();
        n_checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_mag !== 32'd5) begin
            n_errors++;
            $display("FAIL bp_full: occ=%0d ready=%b mag=%0d want 2 0 5", occupancy, in_ready, out_mag);
        end
        drive(32'd7, 1'b0, 4'd7);
        cycle();
        n_checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || obs() !== mk(1'b0, 32'd5, 6'd29, 1'b0, 4'd5)) begin
            n_errors++;
            $display("FAIL bp_stall: occ=%0d ready=%b data=%h want 2 0 %h", occupancy, in_ready, obs(), mk(1'b0, 32'd5, 6'd29, 1'b0, 4'd5));
        end
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_mag !== 32'd6 || out_lzc !== 6'd29) begin
            n_errors++;
            $display("FAIL bp_pop1: occ=%0d ready=%b mag=%0d lzc=%0d want 1 1 6 29", occupancy, in_ready, out_mag, out_lzc);
        end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 2'd1 || obs() !== mk(1'b0, 32'd7, 6'd29, 1'b0, 4'd7)) begin
            n_errors++;
            $display("FAIL bp_pop2: occ=%0d data=%h want 1 %h", occupancy, obs(), mk(1'b0, 32'd7, 6'd29, 1'b0, 4'd7));
        end
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_errors++;
            $display("FAIL bp_drain: valid=%b occ=%0d want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'h11, 1'b0, 4'd1); cycle();
        drive(32'h22, 1'b0, 4'd2); cycle();
        drive(32'd9, 1'b0, 4'd9);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_mag !== 32'h11) begin
            n_errors++;
            $display("FAIL flush_full: valid=%b occ=%0d ready=%b mag=%h want 0 0 1 11", out_valid, occupancy, in_ready, out_mag);
        end
        drive(32'h33, 1'b0, 4'd3); cycle();
        drive(32'd9, 1'b0, 4'd9);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_mag !== 32'h33) begin
            n_errors++;
            $display("FAIL flush_push: valid=%b occ=%0d mag=%h want 0 0 33", out_valid, occupancy, out_mag);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(32'h44, 1'b0, 4'd4); cycle();
        out_ready = 1'b1;
        drive(32'h55, 1'b0, 4'd5);
        rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || obs() !== exp_t'(0)) begin
            n_errors++;
            $display("FAIL reset_mid: valid=%b ready=%b occ=%0d data=%h want 0 1 0 0", out_valid, in_ready, occupancy, obs());
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 32'd0;
                1:       d = 32'h8000_0000;
                2:       d = 32'hFFFF_FFFF;
                3:       d = 32'd1;
                4:       d = $urandom() >> $urandom_range(0, 31);
                default: d = $urandom();
            endcase
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = d;
            in_unsigned = $urandom_range(0, 1) == 1;
            in_tag      = 4'($urandom_range(0, 15));
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            cycle();
            n_checks++;
            if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2) ||
                occupancy !== 2'(m_q.size()) || obs() !== m_shown) begin
                n_errors++;
                $display("FAIL random[%0d]: valid=%b ready=%b occ=%0d data=%h want occ=%0d data=%h",
                         i, out_valid, in_ready, occupancy, obs(), m_q.size(), m_shown);
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle();
    endtask

    initial begin
        m_shown = '0;
        test_reset();
        test_signed_neg_one();
        test_extremes();
        test_zero();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
